// File: rtl/lc3b_types.sv
// Shared LC-3b type definitions: opcodes, redirect-unit FSM states and
// trap vector address constants.
package lc3b_types;

  typedef enum logic [3:0] {
    op_br   = 4'b0000,
    op_add  = 4'b0001,
    op_ldb  = 4'b0010,
    op_stb  = 4'b0011,
    op_jsr  = 4'b0100,
    op_and  = 4'b0101,
    op_ldr  = 4'b0110,
    op_str  = 4'b0111,
    op_rti  = 4'b1000,
    op_not  = 4'b1001,
    op_ldi  = 4'b1010,
    op_sti  = 4'b1011,
    op_jmp  = 4'b1100,
    op_shf  = 4'b1101,
    op_lea  = 4'b1110,
    op_trap = 4'b1111
  } lc3b_opcode;

  typedef enum logic [1:0] {
    S_IDLE      = 2'b00,
    S_TRAP_READ = 2'b01,
    S_REDIRECT  = 2'b10
  } lc3b_redirect_state;

  // Trap vectors index a table of 16-bit words, so the byte offset is vect*2
  localparam int lc3b_trap_shift = 1;

endpackage

// File: rtl/branch_cond_eval.sv
// Evaluates the LC-3b BR condition: taken when any requested condition
// (n, z, p) matches the current condition codes.
module branch_cond_eval (
  input  logic [2:0] nzp,
  input  logic [2:0] cc,
  output logic       taken
);

  assign taken = |(nzp & cc);

endmodule

// File: rtl/branch_redirect_unit.sv
// MEM-stage control-flow resolution for the LC-3b pipeline: classifies
// BR/JMP/JSR/JSRR/TRAP, performs the trap vector read and drives the fetch
// redirect handshake.
// Optional build macro BRANCH_REDIRECT_STATS_EN adds saturating counters of
// taken and not-taken control-flow instructions.
module branch_redirect_unit
  import lc3b_types::*;
#(
  parameter logic [15:0] TRAP_BASE = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        valid_in,
  input  logic [3:0]  opcode,
  input  logic [2:0]  nzp,
  input  logic [2:0]  cc,
  input  logic [15:0] br_target,
  input  logic [15:0] reg_target,
  input  logic        jsr_imm,
  input  logic [7:0]  trapvect8,
  input  logic [15:0] trap_rdata,
  input  logic        trap_resp,
  input  logic        fetch_ready,
  output logic        branch_enable,
  output logic        is_j,
  output logic        is_jsr,
  output logic        is_trap,
  output logic        trap_read,
  output logic [15:0] trap_addr,
  output logic        redirect_valid,
  output logic [15:0] redirect_pc,
  output logic        busy
`ifdef BRANCH_REDIRECT_STATS_EN
  ,
  output logic [15:0] taken_count,
  output logic [15:0] not_taken_count
`endif
);

  lc3b_redirect_state state;
  logic               br_taken;
  logic               detect;
  logic               is_br_op;
  logic               direct_redirect;
  logic [15:0]        sel_target;

  branch_cond_eval u_cond (
    .nzp   (nzp),
    .cc    (cc),
    .taken (br_taken)
  );

  // Classify the MEM-stage instruction and pick its redirect target
  always_comb begin
    detect          = (state == S_IDLE) && valid_in && !stall && !reset;
    is_br_op        = detect && (opcode == op_br);
    branch_enable   = is_br_op && br_taken;
    is_j            = detect && (opcode == op_jmp);
    is_jsr          = detect && (opcode == op_jsr);
    is_trap         = detect && (opcode == op_trap);
    direct_redirect = branch_enable || is_j || is_jsr;
    sel_target      = br_target;
    if (opcode == op_jmp) begin
      sel_target = reg_target;
    end else if (opcode == op_jsr) begin
      sel_target = jsr_imm ? br_target : reg_target;
    end
  end

  // Redirect FSM with registered handshake and status outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= S_IDLE;
      trap_read      <= 1'b0;
      trap_addr      <= 16'h0000;
      redirect_valid <= 1'b0;
      redirect_pc    <= 16'h0000;
      busy           <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (direct_redirect) begin
            redirect_pc    <= sel_target;
            redirect_valid <= 1'b1;
            busy           <= 1'b1;
            state          <= S_REDIRECT;
          end else if (is_trap) begin
            trap_addr <= TRAP_BASE + ({8'h00, trapvect8} << lc3b_trap_shift);
            trap_read <= 1'b1;
            busy      <= 1'b1;
            state     <= S_TRAP_READ;
          end
        end
        S_TRAP_READ: begin
          if (trap_resp) begin
            redirect_pc    <= trap_rdata;
            trap_read      <= 1'b0;
            redirect_valid <= 1'b1;
            state          <= S_REDIRECT;
          end
        end
        S_REDIRECT: begin
          if (fetch_ready) begin
            redirect_valid <= 1'b0;
            busy           <= 1'b0;
            state          <= S_IDLE;
          end
        end
        default: begin
          trap_read      <= 1'b0;
          redirect_valid <= 1'b0;
          busy           <= 1'b0;
          state          <= S_IDLE;
        end
      endcase
    end
  end

`ifdef BRANCH_REDIRECT_STATS_EN
  // Saturating counts of taken (incl. JMP/JSR/TRAP) and not-taken resolutions
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      taken_count     <= 16'h0000;
      not_taken_count <= 16'h0000;
    end else begin
      if ((direct_redirect || is_trap) && (taken_count != 16'hFFFF)) begin
        taken_count <= taken_count + 16'h0001;
      end
      if (is_br_op && !br_taken && (not_taken_count != 16'hFFFF)) begin
        not_taken_count <= not_taken_count + 16'h0001;
      end
    end
  end
`endif

endmodule

// File: doc/branch_redirect_unit.md
Name: branch_redirect_unit

Overview:
- Resolves control-flow instructions (BR, JMP/RET, JSR/JSRR, TRAP) at the MEM stage of the LC-3b pipeline.
- Produces the one-cycle classification strobes consumed by the flush/squash controller: branch_enable, is_j, is_jsr, is_trap.
- Drives the fetch-side PC redirect through a valid/ready handshake.
- For TRAP, performs the vector-table read before redirecting, and holds the pipeline busy meanwhile.

Parameters:
- TRAP_BASE, 16'h0000, base byte address of the trap vector table.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- stall  in  1  global pipeline stall; no new resolution while high
- valid_in  in  1  MEM-stage instruction is valid (not squashed)
- opcode  in  4  lc3b_opcode of MEM-stage instruction
- nzp  in  3  BR condition field IR[11:9]
- cc  in  3  current condition codes {n,z,p}
- br_target  in  16  PC-relative target (BR, JSR)
- reg_target  in  16  base-register target (JMP, JSRR)
- jsr_imm  in  1  IR[11]: 1=JSR (br_target), 0=JSRR (reg_target)
- trapvect8  in  8  TRAP vector
- trap_rdata  in  16  vector-table read data
- trap_resp  in  1  vector-table read complete
- fetch_ready  in  1  fetch accepts redirect this cycle
- branch_enable  out  1  taken-BR strobe
- is_j  out  1  JMP strobe
- is_jsr  out  1  JSR/JSRR strobe
- is_trap  out  1  TRAP strobe
- trap_read  out  1  vector-table read request
- trap_addr  out  16  vector-table address
- redirect_valid  out  1  redirect request to fetch
- redirect_pc  out  16  redirect target
- busy  out  1  unit occupied; upstream must stall

Behaviour:
- Reset (asynchronous): state=S_IDLE. All outputs 0. redirect_pc=0, trap_addr=0. Reset mid-operation abandons any pending trap read or redirect.
- Detect condition: state==S_IDLE && valid_in && !stall.
- BR taken when (nzp & cc)!=0.
  - nzp=000 is never taken.
  - nzp=111 is always taken.
  - A not-taken BR produces no strobe and no redirect.
- Strobes are combinational in the detect cycle only, one-hot: branch_enable (taken BR), is_j (JMP), is_jsr (JSR/JSRR), is_trap (TRAP). They are 0 in all other states.
- Detect of taken BR / JMP / JSR / JSRR:
  - Register target: br_target for BR, reg_target for JMP, selected by jsr_imm for JSR/JSRR.
  - Next state S_REDIRECT.
- Detect of TRAP:
  - Register trap_addr = TRAP_BASE + {7'b0, trapvect8, 1'b0}.
  - Next state S_TRAP_READ.
- S_TRAP_READ:
  - trap_read=1 and busy=1.
  - On trap_resp: latch trap_rdata into redirect_pc, drop trap_read next cycle, go to S_REDIRECT.
  - stall does not affect this state.
- S_REDIRECT:
  - redirect_valid=1, redirect_pc stable, busy=1.
  - Return to S_IDLE the cycle after fetch_ready is sampled high.
  - If fetch_ready is high on the first S_REDIRECT cycle, redirect_valid lasts exactly 1 cycle.
- Latency: detect at cycle N → redirect_valid at N+1 for BR/JMP/JSR. For TRAP, redirect_valid comes one cycle after trap_resp.
- Detect conditions arriving while not in S_IDLE are ignored; busy guarantees upstream holds them.
- Other opcodes have no effect.

Optional Feature:
- Macro: BRANCH_REDIRECT_STATS_EN.
- When defined:
  - Add outputs taken_count[15:0] and not_taken_count[15:0], reset to 0.
  - Count each detected taken/not-taken BR respectively.
  - JMP/JSR/TRAP increment taken_count.
  - Counters saturate at 16'hFFFF.
- When undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Shared package lc3b_types gains:
  - enum lc3b_redirect_state {S_IDLE, S_TRAP_READ, S_REDIRECT}.
  - Constant lc3b_trap_shift=1.
  - Existing op_br/op_jmp/op_jsr/op_trap opcodes are reused.
- One natural sub-module: branch_cond_eval, purely combinational; inputs nzp, cc; output taken.

Test Plan:
- BR nzp=010, cc=010, br_target=16'h3040, fetch_ready=1 → branch_enable pulse at N; redirect_valid=1 with redirect_pc=16'h3040 at N+1 only; busy=1 at N+1.
- BR nzp=100, cc=001, and BR nzp=000, cc=111 → no strobe, no redirect, busy stays 0.
- JSRR jsr_imm=0, reg_target=16'h1234, fetch_ready low 3 cycles then high → is_jsr pulse; redirect_valid held 4 cycles with constant 16'h1234; then S_IDLE.
- TRAP trapvect8=8'h25 → is_trap pulse; trap_addr=16'h004A with trap_read until trap_resp; trap_rdata=16'h5000 → redirect_pc=16'h5000.
- Taken BR with stall=1 for 2 cycles → no strobe until stall=0, then normal; second BR presented while busy → ignored.
- reset asserted mid-S_TRAP_READ → all outputs 0 immediately, state S_IDLE; with BRANCH_REDIRECT_STATS_EN, after 2 taken + 1 not-taken BR counts read 2/1.
